// File: rtl/sixbit_atan_seq_pkg.sv
// Shared constants and state encoding for the sequential 6-bit arctangent unit.
package sixbit_atan_seq_pkg;

    localparam int unsigned WIDTH_DEF   = 6;
    localparam int unsigned TERMS_DEF   = 2;
    localparam int unsigned LATENCY_DEF = 2 + TERMS_DEF * (WIDTH_DEF + 3);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_DIV,
        ST_ACC,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sixbit_div_seq.sv
// Restoring unsigned divider: loads on start, WIDTH iterations, one-cycle done pulse.
module sixbit_div_seq
    import sixbit_atan_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             active;

    logic [WIDTH:0]   shifted;
    logic             take;
    logic [WIDTH-1:0] rem_nxt;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        take    = (shifted >= {1'b0, dvs});
        rem_nxt = take ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            active      <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem         <= '0;
                quo         <= dividend;
                dvs         <= divisor;
                cnt         <= CW'(WIDTH);
                active      <= 1'b1;
                div_by_zero <= (divisor == '0);
            end else if (active) begin
                rem <= rem_nxt;
                quo <= {quo[WIDTH-2:0], take};
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/sixbit_atan_seq.sv
// Sequential atan(x) ~ x - x^3/3 + x^5/5 with fixed latency behind start/busy/done.
// Define SIXBIT_ATAN_SAT_EN to saturate out-of-range results instead of wrapping.
module sixbit_atan_seq
    import sixbit_atan_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned TERMS = TERMS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ain,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             overflow
);

    localparam int unsigned AW = WIDTH + 3;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned KW = $clog2(TERMS + 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] x, x_n;
    logic [WIDTH-1:0] p, p_n;
    logic [AW-1:0]    acc, acc_n;
    logic             pov, pov_n;
    logic             ovf, ovf_n;
    logic [KW-1:0]    k, k_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             busy_n, done_n, overflow_n;
    logic [WIDTH-1:0] out_n;

    logic [PW-1:0]    prod;
    logic [AW-1:0]    acc_t;
    logic             ovf_t;
    logic             div_start_c;
    logic [WIDTH-1:0] div_q;
    logic             div_done;
    logic             div_dz;

    sixbit_div_seq #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (div_start_c),
        .dividend   (prod[WIDTH-1:0]),
        .divisor    (WIDTH'({k, 1'b1})),
        .quotient   (div_q),
        .done       (div_done),
        .div_by_zero(div_dz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            x        <= '0;
            p        <= '0;
            acc      <= '0;
            pov      <= 1'b0;
            ovf      <= 1'b0;
            k        <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out      <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            x        <= x_n;
            p        <= p_n;
            acc      <= acc_n;
            pov      <= pov_n;
            ovf      <= ovf_n;
            k        <= k_n;
            cnt      <= cnt_n;
            busy     <= busy_n;
            done     <= done_n;
            out      <= out_n;
            overflow <= overflow_n;
        end
    end

    always_comb begin
        state_n     = state;
        x_n         = x;
        p_n         = p;
        acc_n       = acc;
        pov_n       = pov;
        ovf_n       = ovf;
        k_n         = k;
        cnt_n       = cnt;
        busy_n      = busy;
        done_n      = 1'b0;
        out_n       = out;
        overflow_n  = overflow;
        div_start_c = 1'b0;
        prod        = PW'(p) * PW'(x);
        // An unfinished or divide-by-zero quotient is treated like a dropped term.
        ovf_t       = ovf | pov | ~div_done | div_dz;
        if (pov || !div_done || div_dz)
            acc_t = acc;
        else if (k[0])
            acc_t = acc - AW'(div_q);
        else
            acc_t = acc + AW'(div_q);

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    x_n     = ain;
                    p_n     = ain;
                    acc_n   = AW'(ain);
                    pov_n   = 1'b0;
                    ovf_n   = 1'b0;
                    k_n     = KW'(1);
                    busy_n  = 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_n   = '0;
                state_n = ST_MUL;
            end
            ST_MUL: begin
                p_n = prod[WIDTH-1:0];
                if (|prod[PW-1:WIDTH])
                    pov_n = 1'b1;
                if (cnt == CW'(1)) begin
                    div_start_c = 1'b1;
                    cnt_n       = '0;
                    state_n     = ST_DIV;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_DIV: begin
                if (cnt == CW'(WIDTH - 1))
                    state_n = ST_ACC;
                else
                    cnt_n = cnt + CW'(1);
            end
            ST_ACC: begin
                acc_n = acc_t;
                ovf_n = ovf_t;
                if (k < KW'(TERMS)) begin
                    k_n     = k + KW'(1);
                    cnt_n   = '0;
                    state_n = ST_MUL;
                end else begin
                    overflow_n = ovf_t | acc_t[AW-1] | (|acc_t[AW-2:WIDTH]);
`ifdef SIXBIT_ATAN_SAT_EN
                    if (acc_t[AW-1])
                        out_n = '0;
                    else if (|acc_t[AW-2:WIDTH])
                        out_n = '1;
                    else
                        out_n = acc_t[WIDTH-1:0];
`else
                    out_n = acc_t[WIDTH-1:0];
`endif
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sixbit_atan_seq.sv
// Scoreboard bench for sixbit_atan_seq: directed spec values, random operands, reset and handshake.
module tb_sixbit_atan_seq;

    localparam int LAT = 20;

    typedef struct packed {
        logic [5:0] val;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] ain;
    logic       busy;
    logic       done;
    logic [5:0] out;
    logic       overflow;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sixbit_atan_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ain     (ain),
        .busy    (busy),
        .done    (done),
        .out     (out),
        .overflow(overflow)
    );

    function automatic exp_t model(input int x);
        int   acc = x;
        int   p   = x;
        bit   pov = 0;
        bit   ovf = 0;
        exp_t e;
        for (int k = 1; k <= 2; k++) begin
            for (int m = 0; m < 2; m++) begin
                p = p * x;
                if (p > 63) pov = 1;
                p = p % 64;
            end
            if (pov) ovf = 1;
            else if (k % 2 == 1) acc = acc - p / (2 * k + 1);
            else acc = acc + p / (2 * k + 1);
        end
        if (acc < 0 || acc > 63) ovf = 1;
`ifdef SIXBIT_ATAN_SAT_EN
        if (acc < 0) e.val = 6'd0;
        else if (acc > 63) e.val = 6'd63;
        else e.val = 6'(acc);
`else
        e.val = 6'(acc);
`endif
        e.ovf = ovf;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [5:0] a);
        start = 1'b1;
        ain   = a;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (done !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        ain   = '0;
        #12;
        checks++;
        if ({busy, done, overflow, out} !== 9'd0) begin
            errors++;
            $display("FAIL reset_state got %b required 0", {busy, done, overflow, out});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [5:0] a_tab [6] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd63, 6'd0};
        exp_t       e_tab [6];
        exp_t       e;
        int         cyc;
        e_tab[0] = '{6'd1, 1'b0};
        e_tab[1] = '{6'd6, 1'b0};
`ifdef SIXBIT_ATAN_SAT_EN
        e_tab[2] = '{6'd0, 1'b1};
`else
        e_tab[2] = '{6'd58, 1'b1};
`endif
        e_tab[3] = '{6'd4, 1'b1};
        e_tab[4] = '{6'd63, 1'b1};
        e_tab[5] = '{6'd0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            sb.push_back(e_tab[i]);
            start_op(a_tab[i]);
            ain = ~a_tab[i];
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL dir_busy ain=%0d got %b required 1", a_tab[i], busy);
            end
            wait_done(1, cyc);
            e = sb.pop_front();
            checks++;
            if (out !== e.val || overflow !== e.ovf) begin
                errors++;
                $display("FAIL dir_result ain=%0d got out=%0d ovf=%b required out=%0d ovf=%b",
                         a_tab[i], out, overflow, e.val, e.ovf);
            end
            checks++;
            if (cyc !== LAT || busy !== 1'b0) begin
                errors++;
                $display("FAIL dir_latency ain=%0d got cyc=%0d busy=%b required cyc=%0d busy=0",
                         a_tab[i], cyc, busy, LAT);
            end
            tick();
            checks++;
            if (done !== 1'b0 || out !== e.val) begin
                errors++;
                $display("FAIL dir_hold ain=%0d got done=%b out=%0d required done=0 out=%0d",
                         a_tab[i], done, out, e.val);
            end
        end
    endtask

    task automatic test_random();
        exp_t       e;
        int         cyc;
        logic [5:0] a;
        for (int i = 0; i < 8; i++) begin
            a = 6'($urandom_range(0, 63));
            sb.push_back(model(int'(a)));
            start_op(a);
            wait_done(1, cyc);
            e = sb.pop_front();
            checks++;
            if (out !== e.val || overflow !== e.ovf || cyc !== LAT) begin
                errors++;
                $display("FAIL rand_result ain=%0d got out=%0d ovf=%b cyc=%0d required out=%0d ovf=%b cyc=%0d",
                         a, out, overflow, cyc, e.val, e.ovf, LAT);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_div();
        exp_t e;
        int   cyc;
        bit   seen;
        start_op(6'd3);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, overflow, out} !== 9'd0) begin
            errors++;
            $display("FAIL rst_mid_div got %b required 0", {busy, done, overflow, out});
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_no_done got activity=1 required 0");
        end
        sb.push_back('{6'd6, 1'b0});
        start_op(6'd2);
        wait_done(1, cyc);
        e = sb.pop_front();
        checks++;
        if (out !== e.val || overflow !== e.ovf || cyc !== LAT) begin
            errors++;
            $display("FAIL rst_after got out=%0d ovf=%b cyc=%0d required out=%0d ovf=%b cyc=%0d",
                     out, overflow, cyc, e.val, e.ovf, LAT);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   cyc;
        sb.push_back('{6'd6, 1'b0});
        start_op(6'd2);
        repeat (4) tick();
        start = 1'b1;
        ain   = 6'd1;
        tick();
        start = 1'b0;
        wait_done(6, cyc);
        e = sb.pop_front();
        checks++;
        if (out !== e.val || overflow !== e.ovf || cyc !== LAT) begin
            errors++;
            $display("FAIL ignore_result got out=%0d ovf=%b cyc=%0d required out=%0d ovf=%b cyc=%0d",
                     out, overflow, cyc, e.val, e.ovf, LAT);
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_idle got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        sb.push_back('{6'd6, 1'b0});
        start = 1'b1;
        ain   = 6'd2;
        tick();
        ain = 6'd1;
        wait_done(1, cyc);
        e = sb.pop_front();
        checks++;
        if (out !== e.val || overflow !== e.ovf || cyc !== LAT) begin
            errors++;
            $display("FAIL b2b_first got out=%0d ovf=%b cyc=%0d required out=%0d ovf=%b cyc=%0d",
                     out, overflow, cyc, e.val, e.ovf, LAT);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap got busy=%b done=%b required 0 0", busy, done);
        end
        sb.push_back('{6'd1, 1'b0});
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart got busy=%b required 1", busy);
        end
        wait_done(1, cyc);
        e = sb.pop_front();
        checks++;
        if (out !== e.val || overflow !== e.ovf || cyc !== LAT) begin
            errors++;
            $display("FAIL b2b_second got out=%0d ovf=%b cyc=%0d required out=%0d ovf=%b cyc=%0d",
                     out, overflow, cyc, e.val, e.ovf, LAT);
        end
        tick();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_empty got %0d required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_div();
        test_ignore_start();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
